// File: rtl/ace_controller.sv
// ace_controller: bridges single-cycle cache-controller requests (read, writeback,
// invalidate) onto ACE read/write channels, one transaction at a time, one beat
// per line.
// Optional feature macro: ACE_TIMEOUT_EN enables a watchdog that aborts a stalled
// transaction after TIMEOUT_CYCLES cycles and reports it as a bus error.
`timescale 1ns/1ps
module ace_controller #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned LINE_WIDTH     = 128,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  // cache controller side
  input  logic                  read_req,
  input  logic                  write_req,
  input  logic                  invalid_req,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [LINE_WIDTH-1:0] wb_data,
  output logic                  ace_ready,
  output logic [LINE_WIDTH-1:0] rd_data,
  output logic                  rd_shared,
  output logic                  bus_error,
  // ACE read address channel
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [3:0]            arsnoop,
  output logic                  arvalid,
  input  logic                  arready,
  // ACE read data channel
  input  logic [LINE_WIDTH-1:0] rdata,
  input  logic [3:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  rack,
  // ACE write address / data / response channels
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [LINE_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  wack
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AR_SEND = 3'd1,
    R_WAIT  = 3'd2,
    WR_SEND = 3'd3,
    B_WAIT  = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam logic [3:0] SnoopReadShared  = 4'b0001;
  localparam logic [3:0] SnoopCleanUnique = 4'b1011;

  // A watchdog limit below 2 leaves no cycle for the slave to respond.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ace_controller: TIMEOUT_CYCLES must be at least 2");
  end

  state_e state_q;
  logic   is_write_q;  // transaction in flight is a writeback
  logic   is_inval_q;  // read-channel transaction is CleanUnique (no fill)
  logic   aw_done_q;   // AW handshake already taken in WR_SEND
  logic   w_done_q;    // W handshake already taken in WR_SEND

  logic ar_fire;
  logic r_fire;
  logic aw_fire;
  logic w_fire;
  logic b_fire;
  logic wr_both_done;
  logic tmo_hit;

  // Channel handshakes as seen this cycle
  assign ar_fire      = arvalid & arready;
  assign r_fire       = rready & rvalid;
  assign aw_fire      = awvalid & awready;
  assign w_fire       = wvalid & wready;
  assign b_fire       = bready & bvalid;
  assign wr_both_done = (aw_done_q | aw_fire) & (w_done_q | w_fire);

  // Response bits with no meaning for this controller
  logic unused_resp_bits;
  assign unused_resp_bits = ^{rresp[2], rresp[0], bresp[0]};

`ifdef ACE_TIMEOUT_EN
  localparam int unsigned    TmoW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_cnt_q;

  // Watchdog: counts every cycle spent waiting on the interconnect
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
    end else if (state_q == IDLE || state_q == DONE) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
    end
  end

  assign tmo_hit = (tmo_cnt_q == TmoLast);
`else
  assign tmo_hit = 1'b0;
`endif

  // Transaction FSM with registered channel and completion outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      is_inval_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      ace_ready  <= 1'b0;
      rd_data    <= '0;
      rd_shared  <= 1'b0;
      bus_error  <= 1'b0;
      araddr     <= '0;
      arsnoop    <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      rack       <= 1'b0;
      awaddr     <= '0;
      awvalid    <= 1'b0;
      wdata      <= '0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      wack       <= 1'b0;
    end else begin
      // completion strobes last exactly one cycle
      ace_ready <= 1'b0;
      rack      <= 1'b0;
      wack      <= 1'b0;
      bus_error <= 1'b0;

      case (state_q)
        IDLE: begin
          if (write_req) begin
            awaddr     <= wb_addr;
            wdata      <= wb_data;
            awvalid    <= 1'b1;
            wvalid     <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            is_write_q <= 1'b1;
            is_inval_q <= 1'b0;
            state_q    <= WR_SEND;
          end else if (invalid_req) begin
            araddr     <= req_addr;
            arsnoop    <= SnoopCleanUnique;
            arvalid    <= 1'b1;
            is_write_q <= 1'b0;
            is_inval_q <= 1'b1;
            state_q    <= AR_SEND;
          end else if (read_req) begin
            araddr     <= req_addr;
            arsnoop    <= SnoopReadShared;
            arvalid    <= 1'b1;
            is_write_q <= 1'b0;
            is_inval_q <= 1'b0;
            state_q    <= AR_SEND;
          end
        end

        AR_SEND: begin
          if (ar_fire) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_q <= R_WAIT;
          end else if (tmo_hit) begin
            arvalid   <= 1'b0;
            ace_ready <= 1'b1;
            rack      <= 1'b1;
            bus_error <= 1'b1;
            state_q   <= DONE;
          end
        end

        R_WAIT: begin
          if (r_fire) begin
            rready <= 1'b0;
            if (!is_inval_q) begin
              rd_data <= rdata;
            end
            rd_shared <= rresp[3];
            ace_ready <= 1'b1;
            rack      <= 1'b1;
            bus_error <= rresp[1];
            state_q   <= DONE;
          end else if (tmo_hit) begin
            rready    <= 1'b0;
            ace_ready <= 1'b1;
            rack      <= 1'b1;
            bus_error <= 1'b1;
            state_q   <= DONE;
          end
        end

        WR_SEND: begin
          if (wr_both_done) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b1;
            state_q <= B_WAIT;
          end else if (tmo_hit) begin
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            ace_ready <= 1'b1;
            wack      <= 1'b1;
            bus_error <= 1'b1;
            state_q   <= DONE;
          end else begin
            // AW and W retire independently; the later one moves us on
            if (aw_fire) begin
              awvalid   <= 1'b0;
              aw_done_q <= 1'b1;
            end
            if (w_fire) begin
              wvalid   <= 1'b0;
              w_done_q <= 1'b1;
            end
          end
        end

        B_WAIT: begin
          if (b_fire) begin
            bready    <= 1'b0;
            ace_ready <= 1'b1;
            wack      <= 1'b1;
            bus_error <= bresp[1];
            state_q   <= DONE;
          end else if (tmo_hit) begin
            bready    <= 1'b0;
            ace_ready <= 1'b1;
            wack      <= 1'b1;
            bus_error <= 1'b1;
            state_q   <= DONE;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ace_controller.sv
// tb_ace_controller: randomized scoreboard bench for ace_controller. Expected
// completions (latency, flags, fill data) are derived from request priority and
// the slave stall counts the bench chooses for each transaction.
`timescale 1ns/1ps
module tb_ace_controller;

  localparam int unsigned AW  = 32;
  localparam int unsigned LW  = 128;
  localparam int          TMO = 8;

  logic          clk;
  logic          reset;
  logic          read_req, write_req, invalid_req;
  logic [AW-1:0] req_addr, wb_addr;
  logic [LW-1:0] wb_data;
  logic          ace_ready;
  logic [LW-1:0] rd_data;
  logic          rd_shared, bus_error;
  logic [AW-1:0] araddr;
  logic [3:0]    arsnoop;
  logic          arvalid, arready;
  logic [LW-1:0] rdata;
  logic [3:0]    rresp;
  logic          rvalid, rready, rack;
  logic [AW-1:0] awaddr;
  logic          awvalid, awready;
  logic [LW-1:0] wdata;
  logic          wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready, wack;

  ace_controller #(
    .ADDR_WIDTH     (AW),
    .LINE_WIDTH     (LW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
    .req_addr(req_addr), .wb_addr(wb_addr), .wb_data(wb_data),
    .ace_ready(ace_ready), .rd_data(rd_data), .rd_shared(rd_shared), .bus_error(bus_error),
    .araddr(araddr), .arsnoop(arsnoop), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .rack(rack),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .wack(wack)
  );

  typedef struct {
    int            kind;       // 0 read, 1 invalidate, 2 write
    int            ready_cyc;
    int            ar_cyc;
    int            aw_cyc;
    int            w_cyc;
    logic [AW-1:0] addr;
    logic [LW-1:0] wd;
    logic [3:0]    snoop;
    logic [LW-1:0] rd_data;
    logic          rd_shared;
    logic          err;
    int            n_ar;
    int            n_aw;
    int            n_w;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // slave behaviour for the transaction in flight
  int            s_ar = 0, s_r = 0, s_aw = 0, s_w = 0, s_b = 0;
  logic [LW-1:0] cur_rdata = '0;
  logic [3:0]    cur_rresp = '0;
  logic [1:0]    cur_bresp = '0;

  // handshakes observed for the current transaction
  int n_ar = 0, n_aw = 0, n_w = 0;

  // reference state of the held fill outputs
  logic [LW-1:0] model_rd     = '0;
  logic          model_shared = 1'b0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave: each channel accepts/responds after a chosen number of waiting cycles
  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    rdata = '0; rresp = '0; bresp = '0;
    forever begin
      @(negedge clk);
      arready = arvalid && (ar_cnt == s_ar);
      ar_cnt  = arvalid ? ar_cnt + 1 : 0;
      rvalid  = rready && (r_cnt == s_r);
      r_cnt   = rready ? r_cnt + 1 : 0;
      awready = awvalid && (aw_cnt == s_aw);
      aw_cnt  = awvalid ? aw_cnt + 1 : 0;
      wready  = wvalid && (w_cnt == s_w);
      w_cnt   = wvalid ? w_cnt + 1 : 0;
      bvalid  = bready && (b_cnt == s_b);
      b_cnt   = bready ? b_cnt + 1 : 0;
      rdata   = cur_rdata;
      rresp   = cur_rresp;
      bresp   = cur_bresp;
    end
  end

  // Monitor: checks channel handshakes and completions against the scoreboard
  initial forever begin
    exp_t e;
    @(negedge clk);
    #1;
    if (arvalid && arready) begin
      n_ar++;
      if (sb_q.size() == 0) chk("ar_unexpected", 128'(1), 128'(0));
      else begin
        chk("ar_addr",  128'(araddr),  128'(sb_q[0].addr));
        chk("ar_snoop", 128'(arsnoop), 128'(sb_q[0].snoop));
        chk("ar_cycle", 128'(cyc),     128'(sb_q[0].ar_cyc));
      end
    end
    if (awvalid && awready) begin
      n_aw++;
      if (sb_q.size() == 0) chk("aw_unexpected", 128'(1), 128'(0));
      else begin
        chk("aw_addr",  128'(awaddr), 128'(sb_q[0].addr));
        chk("aw_cycle", 128'(cyc),    128'(sb_q[0].aw_cyc));
      end
    end
    if (wvalid && wready) begin
      n_w++;
      if (sb_q.size() == 0) chk("w_unexpected", 128'(1), 128'(0));
      else begin
        chk("w_data",  wdata,      sb_q[0].wd);
        chk("w_cycle", 128'(cyc),  128'(sb_q[0].w_cyc));
      end
    end
    if (ace_ready) begin
      if (sb_q.size() == 0) chk("ready_unexpected", 128'(1), 128'(0));
      else begin
        e = sb_q.pop_front();
        chk("ready_cycle", 128'(cyc),       128'(e.ready_cyc));
        chk("rack",        128'(rack),      128'(e.kind != 2));
        chk("wack",        128'(wack),      128'(e.kind == 2));
        chk("bus_error",   128'(bus_error), 128'(e.err));
        chk("rd_data",     rd_data,         e.rd_data);
        chk("rd_shared",   128'(rd_shared), 128'(e.rd_shared));
        chk("ar_count",    128'(n_ar),      128'(e.n_ar));
        chk("aw_count",    128'(n_aw),      128'(e.n_aw));
        chk("w_count",     128'(n_w),       128'(e.n_w));
      end
      n_ar = 0; n_aw = 0; n_w = 0;
    end
  end

  // Drive one request (called at a negedge) and queue its expected outcome
  task automatic issue_txn(input bit wr, input bit inv, input bit rd,
                           input logic [AW-1:0] raddr, input logic [AW-1:0] waddr,
                           input logic [LW-1:0] wd, input logic [LW-1:0] rdv,
                           input logic [3:0] rr, input logic [1:0] br,
                           input int sar, input int sr, input int saw, input int sw,
                           input int sb);
    exp_t e;
    s_ar = sar; s_r = sr; s_aw = saw; s_w = sw; s_b = sb;
    cur_rdata = rdv; cur_rresp = rr; cur_bresp = br;
    e.kind   = wr ? 2 : (inv ? 1 : 0);
    e.addr   = wr ? waddr : raddr;
    e.wd     = wd;
    e.snoop  = inv ? 4'b1011 : 4'b0001;
    e.ar_cyc = cyc + 1 + sar;
    e.aw_cyc = cyc + 1 + saw;
    e.w_cyc  = cyc + 1 + sw;
    e.n_ar   = wr ? 0 : 1;
    e.n_aw   = wr ? 1 : 0;
    e.n_w    = wr ? 1 : 0;
    if (wr) begin
      e.ready_cyc = cyc + 3 + imax(saw, sw) + sb;
      e.err       = br[1];
    end else if (sar >= TMO) begin
      // slave never accepts: watchdog abort TMO cycles after AR_SEND entry
      e.ready_cyc = cyc + 1 + TMO;
      e.err       = 1'b1;
      e.n_ar      = 0;
    end else begin
      e.ready_cyc  = cyc + 3 + sar + sr;
      e.err        = rr[1];
      model_shared = rr[3];
      if (!inv) model_rd = rdv;
    end
    e.rd_data   = model_rd;
    e.rd_shared = model_shared;
    sb_q.push_back(e);
    write_req   = wr;
    invalid_req = inv;
    read_req    = rd;
    req_addr    = raddr;
    wb_addr     = waddr;
    wb_data     = wd;
    @(negedge clk);
    write_req = 1'b0; invalid_req = 1'b0; read_req = 1'b0;
  endtask

  // Wait for completion; optionally fire requests that must be ignored while busy
  task automatic wait_done(input bit spurious);
    int n;
    n = 0;
    while (!ace_ready && n < 300) begin
      if (spurious && $urandom_range(0, 3) == 0) begin
        read_req    = 1'($urandom_range(0, 1));
        invalid_req = 1'($urandom_range(0, 1));
        write_req   = 1'($urandom_range(0, 1));
        req_addr    = $urandom;
        wb_addr     = $urandom;
      end
      @(negedge clk);
      read_req = 1'b0; invalid_req = 1'b0; write_req = 1'b0;
      n++;
    end
    if (!ace_ready) begin
      chk("txn_hang", 128'(0), 128'(1));
      reset = 1'b0;
      sb_q.delete();
      @(negedge clk);
      reset = 1'b1;
      n_ar = 0; n_aw = 0; n_w = 0;
      model_rd = '0; model_shared = 1'b0;
    end
  endtask

  initial begin
    int n;
    logic [LW-1:0] a5;
    reset = 1'b0;
    read_req = 1'b0; write_req = 1'b0; invalid_req = 1'b0;
    req_addr = '0; wb_addr = '0; wb_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", 128'({ace_ready, arvalid, rready, rack, awvalid, wvalid, bready, wack,
                            bus_error, rd_shared}), 128'(0));
    chk("reset_addr", 128'({araddr, awaddr, arsnoop}), 128'(0));
    chk("reset_rd_data", rd_data, '0);
    chk("reset_wdata", wdata, '0);
    @(negedge clk);
    reset = 1'b1;

    // read of 0x1000, always-ready slave, IsShared response
    a5 = {16{8'hA5}};
    @(negedge clk);
    issue_txn(0, 0, 1, 32'h1000, '0, '0, a5, 4'b1000, 2'b00, 0, 0, 0, 0, 0);
    wait_done(0);

    // writeback of 0x2040 with AW stalled, W immediate, B one cycle late
    @(negedge clk);
    issue_txn(1, 0, 0, '0, 32'h2040, rand_line(), '0, 4'b0000, 2'b00, 0, 0, 2, 0, 1);
    wait_done(0);

    // simultaneous read and write: only the write is issued
    @(negedge clk);
    issue_txn(1, 0, 1, 32'h4000, 32'h5000, rand_line(), rand_line(), 4'b0000, 2'b10,
              0, 0, 1, 3, 0);
    wait_done(0);

    // invalidate with SLVERR: error reported, fill data untouched
    @(negedge clk);
    issue_txn(0, 1, 0, 32'h1000, '0, '0, rand_line(), 4'b0010, 2'b00, 0, 0, 0, 0, 0);
    wait_done(0);

    // reset while waiting for read data, then resume
    @(negedge clk);
    issue_txn(0, 0, 1, 32'h3000, '0, '0, rand_line(), 4'b1000, 2'b00, 0, 50, 0, 0, 0);
    n = 0;
    while (!rready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reached_rwait", 128'(rready), 128'(1));
    reset = 1'b0;
    @(negedge clk);
    sb_q.delete();
    n_ar = 0; n_aw = 0; n_w = 0;
    model_rd = '0; model_shared = 1'b0;
    #1;
    chk("rst_mid_ctrl", 128'({ace_ready, arvalid, rready, rack, awvalid, wvalid, bready, wack,
                              bus_error, rd_shared}), 128'(0));
    chk("rst_mid_addr", 128'({araddr, awaddr, arsnoop}), 128'(0));
    chk("rst_mid_rd_data", rd_data, '0);
    reset = 1'b1;
    @(negedge clk);
    issue_txn(0, 0, 1, 32'h3000, '0, '0, a5, 4'b0000, 2'b00, 1, 1, 0, 0, 0);
    wait_done(0);

`ifdef ACE_TIMEOUT_EN
    // arready stuck low: watchdog abort with bus_error
    @(negedge clk);
    issue_txn(0, 0, 1, 32'h6000, '0, '0, rand_line(), 4'b0000, 2'b00, 1000, 0, 0, 0, 0);
    wait_done(0);
`endif

    // randomized mix, including colliding and ignored requests
    for (int t = 0; t < 80; t++) begin
      bit w, i, r;
      w = ($urandom_range(0, 3) == 0);
      i = ($urandom_range(0, 2) == 0);
      r = 1'($urandom_range(0, 1));
      if (!w && !i && !r) r = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      issue_txn(w, i, r, $urandom, $urandom, rand_line(), rand_line(),
                4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      wait_done(1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
